// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS-subset core.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int IMEM_WORDS = 512;
  localparam int DMEM_WORDS = 1024;
  localparam int NUM_REGS   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_ABS   = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ABS
  } alu_op_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_if.sv
// Operand/result bundle between the core's decode logic and its ALU.
interface mips_if;
  import mips_pkg::*;

  alu_op_t           op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] result;
  logic              zero;

  modport master (output op, a, b, shamt, input result, zero);
  modport slave  (input op, a, b, shamt, output result, zero);
endinterface

// File: rtl/mips_alu.sv
// Combinational ALU; shifts operate on b by shamt, ABS operates on a.
module mips_alu
  import mips_pkg::*;
(
  mips_if.slave bus
);

  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;

  assign sa = bus.a;
  assign sb = bus.b;

  // Magnitude wraps, so the most negative value maps onto itself.
  function automatic logic [DATA_W-1:0] abs_wrap(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  always_comb begin
    bus.result = '0;
    case (bus.op)
      ALU_ADD: bus.result = bus.a + bus.b;
      ALU_SUB: bus.result = bus.a - bus.b;
      ALU_AND: bus.result = bus.a & bus.b;
      ALU_OR:  bus.result = bus.a | bus.b;
      ALU_XOR: bus.result = bus.a ^ bus.b;
      ALU_SLT: bus.result = {{(DATA_W-1){1'b0}}, (sa < sb)};
      ALU_SLL: bus.result = bus.b << bus.shamt;
      ALU_SRL: bus.result = bus.b >> bus.shamt;
      ALU_SRA: bus.result = DATA_W'(sb >>> bus.shamt);
      ALU_ABS: bus.result = abs_wrap(sa);
      default: bus.result = '0;
    endcase
  end

  assign bus.zero = (bus.result == '0);

endmodule

// File: rtl/mips_dmem.sv
// Word-addressed data store with combinational read and synchronous write.
module mips_dmem
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [9:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regData [0:DMEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (we) regData[addr] <= wdata;
  end

  assign rdata = regData[addr];

endmodule

// File: rtl/mips_imem.sv
// Instruction store with combinational read; the write port exists only for loading.
module mips_imem
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [8:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regData [0:IMEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (we) regData[addr] <= wdata;
  end

  assign rdata = regData[addr];

endmodule

// File: rtl/mips_regbank.sv
// 32-entry register file, two combinational reads, one synchronous write; $0 is hardwired.
module mips_regbank
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] RegBank [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) RegBank[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : RegBank[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : RegBank[ra2];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-subset core: every instruction fetches, executes and retires in one clock.
module mips_cpu
  import mips_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic [DATA_W-1:0] pc, pc_next, pc_plus4, instr;
  logic [DATA_W-1:0] rs_val, rt_val, wb_val, mem_rdata, imm_sext, imm_zext, alu_b;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt, wa;
  logic              reg_we, mem_we, mem_to_reg;
  alu_op_t           alu_op;

  mips_if alu_bus ();

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = sext16(instr[15:0]);
  assign imm_zext = {16'h0000, instr[15:0]};
  assign pc_plus4 = pc + 32'd4;

  mips_imem InstructionMemory (
    .clk, .we(1'b0), .addr(pc[10:2]), .wdata('0), .rdata(instr)
  );

  // Architectural writes are gated by rst so an edge during reset retires nothing.
  mips_regbank RegBank (
    .clk, .we(reg_we & ~rst), .ra1(rs), .ra2(rt), .wa, .wd(wb_val),
    .rd1(rs_val), .rd2(rt_val)
  );

  mips_dmem DataMemory (
    .clk, .we(mem_we & ~rst), .addr(alu_bus.result[11:2]), .wdata(rt_val),
    .rdata(mem_rdata)
  );

  assign alu_bus.op    = alu_op;
  assign alu_bus.a     = rs_val;
  assign alu_bus.b     = alu_b;
  assign alu_bus.shamt = shamt;

  mips_alu Alu (.bus(alu_bus));

  assign wb_val = mem_to_reg ? mem_rdata : alu_bus.result;

  always_comb begin
    alu_op     = ALU_ADD;
    alu_b      = rt_val;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    wa         = rd;
    pc_next    = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            reg_we  = 1'b0;
            pc_next = rs_val;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ABS: begin
        alu_op = ALU_ABS;
        reg_we = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        alu_b  = imm_sext;
        reg_we = 1'b1;
        wa     = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        alu_op = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
        alu_b  = imm_zext;
        reg_we = 1'b1;
        wa     = rt;
      end
      OP_LW: begin
        alu_b      = imm_sext;
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        wa         = rt;
      end
      OP_SW: begin
        alu_b  = imm_sext;
        mem_we = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        if (alu_bus.zero) pc_next = pc_plus4 + (imm_sext << 2);
      end
      OP_J: pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= pc_next;
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Directed and random programs for mips_cpu, checked against an instruction-level model.
module tb_mips_cpu;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_cpu dut (.clk(clk), .rst(rst));

  mips_if alu_chk ();
  mips_alu alu_u (.bus(alu_chk));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_imem [512];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs_i,
      input logic [4:0] rt_i, input logic [4:0] rd_i, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs_i, rt_i, rd_i, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_i,
      input logic [4:0] rt_i, input logic [15:0] imm);
    return {op, rs_i, rt_i, imm};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++)   m_reg[i]  = 32'h0;
    for (int i = 0; i < 1024; i++) m_dmem[i] = 32'h0;
    for (int i = 0; i < 512; i++)  m_imem[i] = 32'h0;
  endtask

  // Instruction-set-level model: one call retires the instruction at m_pc.
  task automatic model_step();
    logic [31:0] ins, a, b, val, nxt, se, ze, addr;
    logic [5:0] op, fn;
    int dst;
    ins = m_imem[m_pc[10:2]];
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = m_reg[ins[25:21]];
    b   = m_reg[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    addr = a + se;
    nxt = m_pc + 4;
    dst = -1;
    val = 0;
    case (op)
      6'h00: begin
        dst = ins[15:11];
        case (fn)
          6'h20: val = a + b;
          6'h22: val = a - b;
          6'h25: val = a | b;
          6'h26: val = a ^ b;
          6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: val = b << ins[10:6];
          6'h02: val = b >> ins[10:6];
          6'h03: val = $signed(b) >>> ins[10:6];
          6'h08: begin nxt = a; dst = -1; end
          default: dst = -1;
        endcase
      end
      6'h21: begin dst = ins[15:11]; val = $signed(a) < 0 ? 32'd0 - a : a; end
      6'h08, 6'h09: begin dst = ins[20:16]; val = a + se; end
      6'h0C: begin dst = ins[20:16]; val = a & ze; end
      6'h0D: begin dst = ins[20:16]; val = a | ze; end
      6'h0E: begin dst = ins[20:16]; val = a ^ ze; end
      6'h23: begin dst = ins[20:16]; val = m_dmem[addr[11:2]]; end
      6'h2B: m_dmem[addr[11:2]] = b;
      6'h04: if (a == b) nxt = m_pc + 4 + (se * 4);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (dst > 0) m_reg[dst] = val;
    m_pc = nxt;
  endtask

  // Backdoor load of the model's state into the core; only done while rst holds writes off.
  task automatic push();
    for (int i = 0; i < 512; i++)  dut.InstructionMemory.regData[i] <= m_imem[i];
    for (int i = 0; i < 1024; i++) dut.DataMemory.regData[i] <= m_dmem[i];
    for (int i = 0; i < 32; i++)   dut.RegBank.RegBank[i] <= m_reg[i];
    #1;
  endtask

  task automatic start(input string tag);
    rst = 1'b1;
    @(negedge clk);
    push();
    m_pc = 32'h0;
    check({tag, " reset pc"}, dut.pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s r%0d", tag, i), dut.RegBank.RegBank[i], m_reg[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [9];
    logic [5:0] iops [5];
    logic [4:0] ra, rb, rc;
    fl   = '{6'h20, 6'h22, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};
    iops = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
    ra = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 8: return enc_r(6'h00, ra, rb, rc, 5'($urandom), fl[$urandom_range(0, 8)]);
      2: return enc_r(6'h21, ra, rb, rc, 5'd0, 6'd0);
      3: return enc_i(iops[$urandom_range(0, 4)], ra, rb, 16'($urandom));
      4: return enc_i(6'h23, ra, rb, 16'($urandom));
      5: return enc_i(6'h2B, ra, rb, 16'($urandom));
      6: return enc_i(6'h04, ra, ($urandom_range(0, 1) != 0) ? ra : rb, 16'($urandom_range(0, 15)));
      7: return {6'h02, 26'($urandom_range(0, 511))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ALU edge cases through the interface
    alu_chk.op = ALU_ABS; alu_chk.a = 32'h8000_0000; alu_chk.b = 32'h0; alu_chk.shamt = 5'd0;
    #1 check("alu abs min", alu_chk.result, 32'h8000_0000);
    alu_chk.op = ALU_ADD; alu_chk.a = 32'hFFFF_FFFF; alu_chk.b = 32'h1;
    #1 check("alu add wrap", alu_chk.result, 32'h0);
    check("alu zero flag", {31'h0, alu_chk.zero}, 32'h1);
    alu_chk.op = ALU_SRA; alu_chk.b = 32'h8000_0000; alu_chk.shamt = 5'd31;
    #1 check("alu sra", alu_chk.result, 32'hFFFF_FFFF);

    // Arithmetic, logic, shifts, ABS and immediates
    clear_model();
    m_reg[1] = 32'd10; m_reg[2] = 32'd9; m_reg[31] = -32'sd5;
    m_imem[0]  = enc_r(6'h00, 1, 2, 16, 0, 6'h20);
    m_imem[1]  = enc_r(6'h00, 1, 2, 3, 0, 6'h25);
    m_imem[2]  = enc_r(6'h00, 1, 2, 4, 0, 6'h2A);
    m_imem[3]  = enc_r(6'h00, 1, 2, 5, 0, 6'h22);
    m_imem[4]  = enc_r(6'h00, 1, 2, 6, 0, 6'h26);
    m_imem[5]  = enc_r(6'h00, 0, 1, 7, 2, 6'h00);
    m_imem[6]  = enc_r(6'h00, 0, 1, 8, 2, 6'h02);
    m_imem[7]  = enc_r(6'h21, 31, 0, 10, 0, 6'h00);
    m_imem[8]  = enc_i(6'h08, 1, 11, 16'd15);
    m_imem[9]  = enc_i(6'h09, 1, 12, 16'd16);
    m_imem[10] = enc_i(6'h0C, 2, 13, 16'd2);
    m_imem[11] = enc_i(6'h0D, 2, 14, 16'd3);
    m_imem[12] = enc_i(6'h0E, 2, 15, 16'd7);
    m_imem[13] = enc_r(6'h00, 1, 2, 0, 0, 6'h20);
    start("p1");
    for (int i = 0; i < 14; i++) step();
    check("add r16", dut.RegBank.RegBank[16], 32'd19);
    check("or r3",   dut.RegBank.RegBank[3],  32'd11);
    check("slt r4",  dut.RegBank.RegBank[4],  32'd0);
    check("sub r5",  dut.RegBank.RegBank[5],  32'd1);
    check("xor r6",  dut.RegBank.RegBank[6],  32'd3);
    check("sll r7",  dut.RegBank.RegBank[7],  32'd40);
    check("srl r8",  dut.RegBank.RegBank[8],  32'd2);
    check("abs r10", dut.RegBank.RegBank[10], 32'd5);
    check("addi r11",  dut.RegBank.RegBank[11], 32'd25);
    check("addiu r12", dut.RegBank.RegBank[12], 32'd26);
    check("andi r13",  dut.RegBank.RegBank[13], 32'd0);
    check("ori r14",   dut.RegBank.RegBank[14], 32'd11);
    check("xori r15",  dut.RegBank.RegBank[15], 32'd14);
    check("r0 stays zero", dut.RegBank.RegBank[0], 32'd0);
    check("p1 pc", dut.pc, 32'd56);
    check_regs("p1");

    // Signed shift and signed compare
    clear_model();
    m_reg[1] = 32'hFFFF_FFF8; m_reg[2] = 32'd9;
    m_imem[0] = enc_r(6'h00, 0, 1, 9, 2, 6'h03);
    m_imem[1] = enc_r(6'h00, 1, 2, 4, 0, 6'h2A);
    start("p2");
    step(); step();
    check("sra r9", dut.RegBank.RegBank[9], 32'hFFFF_FFFE);
    check("slt neg r4", dut.RegBank.RegBank[4], 32'd1);

    // Memory, branches and jumps
    clear_model();
    m_dmem[1] = 32'd10;
    m_reg[1] = 32'd4; m_reg[2] = 32'd9; m_reg[22] = 32'd4; m_reg[21] = 32'h55; m_reg[20] = 32'd100;
    m_imem[0]  = enc_i(6'h23, 1, 19, 16'd0);
    m_imem[1]  = enc_i(6'h2B, 1, 21, 16'd0);
    m_imem[2]  = enc_i(6'h04, 1, 22, 16'd2);
    m_imem[5]  = enc_i(6'h04, 1, 2, 16'd2);
    m_imem[6]  = enc_r(6'h00, 20, 0, 0, 0, 6'h08);
    m_imem[25] = {6'h02, 26'd1};
    start("p3");
    step(); check("lw r19", dut.RegBank.RegBank[19], 32'd10);
    step(); check("sw dmem1", dut.DataMemory.regData[1], 32'h55);
    step(); check("beq taken pc", dut.pc, 32'd20);
    step(); check("beq not taken pc", dut.pc, 32'd24);
    step(); check("jr pc", dut.pc, 32'd100);
    step(); check("j pc", dut.pc, 32'd4);
    check_regs("p3");

    // Random program against the model, with a reset in the middle
    clear_model();
    for (int i = 1; i < 32; i++)   m_reg[i]  = $urandom;
    for (int i = 0; i < 1024; i++) m_dmem[i] = $urandom;
    for (int i = 0; i < 512; i++)  m_imem[i] = rand_instr();
    start("rnd");
    for (int s = 0; s < 300; s++) begin
      step();
      check($sformatf("rnd pc %0d", s), dut.pc, m_pc);
      check_regs($sformatf("rnd %0d", s));
    end
    @(negedge clk);
    rst = 1'b1;
    #1 check("async reset pc", dut.pc, 32'h0);
    @(posedge clk);
    #1 check("reset held pc", dut.pc, 32'h0);
    check_regs("reset held");
    for (int i = 0; i < 1024; i++)
      check($sformatf("reset held dmem %0d", i), dut.DataMemory.regData[i], m_dmem[i]);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0;
    for (int s = 0; s < 60; s++) begin
      step();
      check($sformatf("restart pc %0d", s), dut.pc, m_pc);
      check_regs($sformatf("restart %0d", s));
    end
    for (int i = 0; i < 1024; i++)
      check($sformatf("final dmem %0d", i), dut.DataMemory.regData[i], m_dmem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
